pic_ack_sequencer: RTL
======================

# pic_ack_sequencer

Clocked interrupt-acknowledge controller for the 8-input programmable interrupt controller. Resolves the highest-priority unmasked request against in-service levels, raises INT, runs the two-pulse x86 INTA handshake, sets and clears ISR, pulses IRR-bit clears, drives the vector byte, and executes EOI, AEOI and rotate-on-EOI commands. It sits between the IRR/IMR register block and the data-bus buffer, replacing the INTA-edge-clocked resolver with a single-clock design.

## Interface
- NUM_IR, 8, number of request levels (fixed at 8; level index is 3 bits)
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- IRR  in  8  pending requests from IRR block (bit0 = IR0)
- IMR  in  8  mask; 1 = level masked
- VEC_BASE  in  5  ICW2 T7..T3
- AEOI  in  1  automatic EOI mode
- INTA_N  in  1  CPU acknowledge strobe, already synchronised to CLK, active low
- EOI_VALID  in  1  one-cycle OCW2 EOI command strobe
- EOI_SPECIFIC  in  1  1 = specific EOI using EOI_LEVEL
- EOI_LEVEL  in  3  level for specific EOI
- EOI_ROTATE  in  1  rotate priority on this EOI
- INT  out  1  interrupt request to CPU
- ISR  out  8  in-service register
- IRR_CLR  out  8  one-cycle one-hot clear of the acknowledged IRR bit
- DOUT  out  8  vector byte {VEC_BASE, level}
- DOUT_OE  out  1  DOUT valid/drive enable
- LOW_PRIO  out  3  current lowest-priority level

## Operation
- Priority: rotating; highest = LOW_PRIO+1 mod 8, descending around the ring. Reset LOW_PRIO = 7, so IR0 is highest.
- Candidate = highest-priority bit of IRR & ~IMR. It is eligible only if it is strictly higher than the highest set ISR bit (fully nested mode).
- INTA_N edges: prev register holds last sample. Fall = prev 1, now 0; rise = prev 0, now 1.
- FSM states: IDLE, PEND, ACK1, WAIT2, ACK2.
  - IDLE: eligible candidate -> PEND; INT = 1.
  - PEND: candidate lost before any fall -> IDLE; INT = 0. Fall -> ACK1: latch level L = candidate. If none, L = 7 (spurious). Non-spurious: set ISR[L] and pulse IRR_CLR[L]. Spurious: no ISR set, no IRR_CLR. INT = 0.
  - ACK1: rise -> WAIT2.
  - WAIT2: fall -> ACK2; DOUT = {VEC_BASE, L}; DOUT_OE = 1.
  - ACK2: rise -> IDLE; DOUT_OE = 0. If AEOI and not spurious, clear ISR[L]. If AEOI and EOI_ROTATE, LOW_PRIO = L.
- A fall seen in IDLE, or a second fall in ACK1, is ignored.
- EOI (any state):
  - Non-specific: clears the highest-priority set ISR bit; no-op if ISR = 0.
  - Specific: clears ISR[EOI_LEVEL].
  - With EOI_ROTATE: LOW_PRIO = cleared level. No change if nothing was cleared.
- Same-cycle EOI and ISR set: the clear is computed on the old ISR, then the set is applied; the new bit survives.

## Timing
- Reset values: INT 0, ISR 0, IRR_CLR 0, DOUT 0, DOUT_OE 0, LOW_PRIO 7; FSM = IDLE; prev INTA_N = 1.
- INT asserts 1 cycle after the candidate appears in IDLE.
- ISR set, IRR_CLR pulse and INT deassert appear 1 cycle after the cycle in which the first fall is detected. IRR_CLR is high for exactly 1 cycle.
- DOUT/DOUT_OE become valid 1 cycle after the second fall is detected. They drop 1 cycle after the rise is detected.
- EOI takes effect on ISR/LOW_PRIO at the next edge.
- RST_N low in any state: all outputs return to reset values at that edge; no IRR_CLR is issued.

## Structure
- Shared package pic_pkg: state enum (IDLE, PEND, ACK1, WAIT2, ACK2), NUM_IR, level type (3-bit), SPURIOUS_LEVEL = 7.
- One sub-module, pic_prio_rotate: combinational rotating find-first. Inputs: 8-bit vector, LOW_PRIO. Outputs: valid and 3-bit level. Instantiated twice, once for the candidate and once for the highest ISR bit / non-specific EOI.

## Test plan
- IRR = 0x24, IMR = 0 -> INT = 1. Two INTA pulses -> ISR = 0x04, IRR_CLR = 0x04 for 1 cycle, DOUT = 0x42 with VEC_BASE = 0x08.
- ISR = 0x04, IRR = 0x08 -> INT stays 0. IRR = 0x02 -> INT = 1 and the nested ack gives ISR = 0x06. Non-specific EOI -> ISR = 0x04.
- INT raised for IR3, then IRR drops to 0 after INT but before the first INTA fall -> FSM returns to IDLE, INT = 0. If IRR instead drops between the FSM check and the fall, INTA proceeds spurious: DOUT low bits = 7, ISR unchanged, IRR_CLR = 0.
- AEOI = 1, IRR = 0x01 -> after the second rise ISR = 0x00.
- Specific EOI level 5 with rotate, ISR = 0x20 -> ISR = 0, LOW_PRIO = 5. Then IRR = 0x41 -> IR6 is acknowledged first.
- RST_N low during WAIT2 -> next edge: DOUT_OE = 0, ISR = 0, INT = 0, LOW_PRIO = 7; the following INTA rise is ignored.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and helpers for the interrupt-acknowledge sequencer
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam int LVL_W  = 3;

    typedef logic [LVL_W-1:0] level_t;

    localparam level_t SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4
    } state_t;

    // Rank of a level in the rotating ring: 0 = highest priority (LOW_PRIO+1).
    function automatic level_t prio_rank(input level_t lvl, input level_t low_prio);
        return lvl - low_prio - 3'd1;
    endfunction

    function automatic logic [NUM_IR-1:0] lvl_onehot(input level_t lvl);
        return NUM_IR'(1) << lvl;
    endfunction

endpackage

// File: rtl/pic_prio_rotate.sv
// rtl/pic_prio_rotate.sv - combinational rotating find-first over 8 request levels
module pic_prio_rotate
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec,
    input  level_t            low_prio,
    output logic              valid,
    output level_t            level
);

    // Walk from lowest to highest priority so the highest set bit wins last.
    always_comb begin
        level_t idx;
        idx   = '0;
        valid = 1'b0;
        level = '0;
        for (int i = NUM_IR; i >= 1; i--) begin
            idx = low_prio + level_t'(i);
            if (vec[idx]) begin
                valid = 1'b1;
                level = idx;
            end
        end
    end

endmodule

// File: rtl/pic_ack_sequencer.sv
// rtl/pic_ack_sequencer.sv - single-clock INTA handshake, ISR and EOI control for 8 levels
module pic_ack_sequencer
    import pic_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_IR-1:0] IRR,
    input  logic [NUM_IR-1:0] IMR,
    input  logic [4:0]        VEC_BASE,
    input  logic              AEOI,
    input  logic              INTA_N,
    input  logic              EOI_VALID,
    input  logic              EOI_SPECIFIC,
    input  logic [2:0]        EOI_LEVEL,
    input  logic              EOI_ROTATE,
    output logic              INT,
    output logic [NUM_IR-1:0] ISR,
    output logic [NUM_IR-1:0] IRR_CLR,
    output logic [7:0]        DOUT,
    output logic              DOUT_OE,
    output logic [2:0]        LOW_PRIO
);

    state_t            state_q, state_d;
    logic              inta_prev_q;
    logic              int_q, int_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [NUM_IR-1:0] irr_clr_q, irr_clr_d;
    logic [7:0]        dout_q, dout_d;
    logic              dout_oe_q, dout_oe_d;
    level_t            low_q, low_d;
    level_t            lvl_q, lvl_d;
    logic              spur_q, spur_d;

    logic              inta_fall, inta_rise;
    logic [NUM_IR-1:0] req_vec;
    logic              cand_valid, isr_valid, eligible;
    level_t            cand_lvl, isr_lvl;

    assign inta_fall = inta_prev_q & ~INTA_N;
    assign inta_rise = ~inta_prev_q & INTA_N;
    assign req_vec   = IRR & ~IMR;

    pic_prio_rotate u_cand (
        .vec      (req_vec),
        .low_prio (low_q),
        .valid    (cand_valid),
        .level    (cand_lvl)
    );

    pic_prio_rotate u_isr (
        .vec      (isr_q),
        .low_prio (low_q),
        .valid    (isr_valid),
        .level    (isr_lvl)
    );

    // Fully nested: a request only interrupts if it outranks everything in service.
    assign eligible = cand_valid &
                      (~isr_valid | (prio_rank(cand_lvl, low_q) < prio_rank(isr_lvl, low_q)));

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            int_q       <= 1'b0;
            isr_q       <= '0;
            irr_clr_q   <= '0;
            dout_q      <= '0;
            dout_oe_q   <= 1'b0;
            low_q       <= 3'd7;
            lvl_q       <= '0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= INTA_N;
            int_q       <= int_d;
            isr_q       <= isr_d;
            irr_clr_q   <= irr_clr_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
            low_q       <= low_d;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
        end
    end

    // Next state of the two-pulse acknowledge handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (eligible) state_d = PEND;
            PEND: begin
                if (inta_fall)        state_d = ACK1;
                else if (!cand_valid) state_d = IDLE;
            end
            ACK1:    if (inta_rise) state_d = WAIT2;
            WAIT2:   if (inta_fall) state_d = ACK2;
            ACK2:    if (inta_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs, ISR and rotation; EOI clears are taken from the old ISR before any new set.
    always_comb begin
        logic              eoi_hit;
        level_t            eoi_lvl;
        logic [NUM_IR-1:0] clr_mask;
        logic [NUM_IR-1:0] set_mask;

        int_d     = 1'b0;
        irr_clr_d = '0;
        dout_d    = dout_q;
        dout_oe_d = dout_oe_q;
        lvl_d     = lvl_q;
        spur_d    = spur_q;
        low_d     = low_q;
        clr_mask  = '0;
        set_mask  = '0;
        eoi_hit   = 1'b0;
        eoi_lvl   = '0;

        case (state_q)
            IDLE: int_d = eligible;
            PEND: begin
                int_d = cand_valid & ~inta_fall;
                if (inta_fall) begin
                    lvl_d  = cand_valid ? cand_lvl : SPURIOUS_LEVEL;
                    spur_d = ~cand_valid;
                    if (cand_valid) begin
                        set_mask  = lvl_onehot(cand_lvl);
                        irr_clr_d = lvl_onehot(cand_lvl);
                    end
                end
            end
            WAIT2: begin
                if (inta_fall) begin
                    dout_d    = {VEC_BASE, lvl_q};
                    dout_oe_d = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    dout_d    = '0;
                    dout_oe_d = 1'b0;
                    if (AEOI && !spur_q) clr_mask = lvl_onehot(lvl_q);
                    if (AEOI && EOI_ROTATE) low_d = lvl_q;
                end
            end
            default: ;
        endcase

        if (EOI_VALID) begin
            if (EOI_SPECIFIC) begin
                eoi_hit = isr_q[EOI_LEVEL];
                eoi_lvl = EOI_LEVEL;
            end else begin
                eoi_hit = isr_valid;
                eoi_lvl = isr_lvl;
            end
            if (eoi_hit) begin
                clr_mask = clr_mask | lvl_onehot(eoi_lvl);
                if (EOI_ROTATE) low_d = eoi_lvl;
            end
        end

        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    assign INT      = int_q;
    assign ISR      = isr_q;
    assign IRR_CLR  = irr_clr_q;
    assign DOUT     = dout_q;
    assign DOUT_OE  = dout_oe_q;
    assign LOW_PRIO = low_q;

endmodule
